// File: rtl/regfile_writeback_master.sv
// Writeback initiator for the 32x32 register file: arbitrates ALU/load requests into a
// small FIFO, drains one write per clock, and reports pending writes for hazard/forwarding.
module regfile_writeback_master #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [4:0]                    mem_rd,
  input  logic [XLEN-1:0]               mem_data,
  input  logic                          stall,
  output logic                          rf_wr_en,
  output logic [4:0]                    rf_write_select,
  output logic [XLEN-1:0]               rf_data_in,
  input  logic [4:0]                    query_rd_1,
  input  logic [4:0]                    query_rd_2,
  output logic                          busy_1,
  output logic                          busy_2,
  output logic [XLEN-1:0]               fwd_data_1,
  output logic [XLEN-1:0]               fwd_data_2,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned RW = 5;

  typedef struct packed {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  wb_entry_t       fifo_q [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            not_full;
  logic            push_fire;
  logic            push_en;
  logic            pop_en;
  wb_entry_t       push_ent;

  // Load unit has fixed priority; ready reflects only the registered occupancy.
  assign not_full  = (count < CW'(DEPTH));
  assign mem_ready = ~reset & not_full;
  assign alu_ready = ~reset & not_full & ~mem_valid;

  always_comb begin
    push_ent = '0;
    if (mem_valid) begin
      push_ent.rd   = mem_rd;
      push_ent.data = mem_data;
    end else begin
      push_ent.rd   = alu_rd;
      push_ent.data = alu_data;
    end
  end

  // Writes to x0 complete the handshake but are dropped here.
  assign push_fire = (mem_valid & mem_ready) | (alu_valid & alu_ready);
  assign push_en   = push_fire & (push_ent.rd != RW'(0));
  assign pop_en    = (count != CW'(0)) & ~stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      rf_wr_en        <= 1'b0;
      rf_write_select <= '0;
      rf_data_in      <= '0;
    end else begin
      if (push_en) begin
        fifo_q[wr_ptr] <= push_ent;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      rf_wr_en <= pop_en;
      if (pop_en) begin
        rf_write_select <= fifo_q[rd_ptr].rd;
        rf_data_in      <= fifo_q[rd_ptr].data;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push_en) - CW'(pop_en);
    end
  end

  // Youngest match wins: output register first, then FIFO entries oldest to youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    busy_1     = 1'b0;
    busy_2     = 1'b0;
    fwd_data_1 = '0;
    fwd_data_2 = '0;
    if (rf_wr_en && (rf_write_select == query_rd_1)) begin
      busy_1     = 1'b1;
      fwd_data_1 = rf_data_in;
    end
    if (rf_wr_en && (rf_write_select == query_rd_2)) begin
      busy_2     = 1'b1;
      fwd_data_2 = rf_data_in;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < count) begin
        if (fifo_q[idx].rd == query_rd_1) begin
          busy_1     = 1'b1;
          fwd_data_1 = fifo_q[idx].data;
        end
        if (fifo_q[idx].rd == query_rd_2) begin
          busy_2     = 1'b1;
          fwd_data_2 = fifo_q[idx].data;
        end
      end
    end
    if (query_rd_1 == RW'(0)) begin
      busy_1     = 1'b0;
      fwd_data_1 = '0;
    end
    if (query_rd_2 == RW'(0)) begin
      busy_2     = 1'b0;
      fwd_data_2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_master.sv
// Directed bench for regfile_writeback_master: per-cycle vector table plus reset sequences.
module tb_regfile_writeback_master;

  logic        clock;
  logic        reset;
  logic        alu_valid, mem_valid, stall;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd, query_rd_1, query_rd_2;
  logic [31:0] alu_data, mem_data;
  logic        rf_wr_en;
  logic [4:0]  rf_write_select;
  logic [31:0] rf_data_in;
  logic        busy_1, busy_2;
  logic [31:0] fwd_data_1, fwd_data_2;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  regfile_writeback_master #(.XLEN(32), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .stall(stall),
    .rf_wr_en(rf_wr_en), .rf_write_select(rf_write_select), .rf_data_in(rf_data_in),
    .query_rd_1(query_rd_1), .query_rd_2(query_rd_2),
    .busy_1(busy_1), .busy_2(busy_2), .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        stl;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_mr;
    logic        e_ar;
    logic        e_b1;
    logic [31:0] e_f1;
    logic        e_b2;
    logic [31:0] e_f2;
    logic        e_we;
    logic [4:0]  e_sel;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic stl);
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    stall = stl;
  endtask

  task automatic chk_regs(input string tag, input logic we, input logic [4:0] sel,
                          input logic [31:0] data, input logic [2:0] cnt);
    chk({tag, ".wr_en"}, 32'(rf_wr_en), 32'(we));
    chk({tag, ".sel"},   32'(rf_write_select), 32'(sel));
    chk({tag, ".data"},  rf_data_in, data);
    chk({tag, ".count"}, 32'(count), 32'(cnt));
  endtask

  initial begin
    // Test 1: single ALU write and its latency
    vecs[0]  = '{0,0,0, 1,5,32'hDEADBEEF, 0, 5,0, 1,1,0,0,0,0, 0,0,0,1};
    vecs[1]  = '{0,0,0, 0,0,0, 0, 5,0, 1,1,1,32'hDEADBEEF,0,0, 1,5,32'hDEADBEEF,0};
    vecs[2]  = '{0,0,0, 0,0,0, 0, 5,0, 1,1,1,32'hDEADBEEF,0,0, 0,5,32'hDEADBEEF,0};
    // Test 2: load unit wins arbitration, ordering preserved
    vecs[3]  = '{1,3,32'h33, 1,4,32'h44, 0, 3,0, 1,0,0,0,0,0, 0,5,32'hDEADBEEF,1};
    vecs[4]  = '{0,0,0, 1,4,32'h44, 0, 4,0, 1,1,0,0,0,0, 1,3,32'h33,1};
    vecs[5]  = '{0,0,0, 0,0,0, 0, 4,3, 1,1,1,32'h44,1,32'h33, 1,4,32'h44,0};
    vecs[6]  = '{0,0,0, 0,0,0, 0, 4,0, 1,1,1,32'h44,0,0, 0,4,32'h44,0};
    // Test 3: fill under stall, full back-pressure, drain in order
    vecs[7]  = '{0,0,0, 1,10,32'hA0, 1, 10,0, 1,1,0,0,0,0, 0,4,32'h44,1};
    vecs[8]  = '{0,0,0, 1,11,32'hB0, 1, 10,0, 1,1,1,32'hA0,0,0, 0,4,32'h44,2};
    vecs[9]  = '{1,12,32'hC0, 0,0,0, 1, 12,0, 1,0,0,0,0,0, 0,4,32'h44,3};
    vecs[10] = '{0,0,0, 1,13,32'hD0, 1, 12,0, 1,1,1,32'hC0,0,0, 0,4,32'h44,4};
    vecs[11] = '{0,0,0, 1,14,32'hE0, 1, 13,0, 0,0,1,32'hD0,0,0, 0,4,32'h44,4};
    vecs[12] = '{0,0,0, 1,14,32'hE0, 0, 13,11, 0,0,1,32'hD0,1,32'hB0, 1,10,32'hA0,3};
    vecs[13] = '{0,0,0, 1,14,32'hE0, 0, 14,10, 1,1,0,0,1,32'hA0, 1,11,32'hB0,3};
    vecs[14] = '{0,0,0, 0,0,0, 0, 14,0, 1,1,1,32'hE0,0,0, 1,12,32'hC0,2};
    vecs[15] = '{0,0,0, 0,0,0, 0, 14,0, 1,1,1,32'hE0,0,0, 1,13,32'hD0,1};
    vecs[16] = '{0,0,0, 0,0,0, 0, 13,0, 1,1,1,32'hD0,0,0, 1,14,32'hE0,0};
    vecs[17] = '{0,0,0, 0,0,0, 0, 14,0, 1,1,1,32'hE0,0,0, 0,14,32'hE0,0};
    // Test 4: two pending writes to the same rd, youngest forwarded
    vecs[18] = '{0,0,0, 1,7,32'h1, 1, 7,0, 1,1,0,0,0,0, 0,14,32'hE0,1};
    vecs[19] = '{0,0,0, 1,7,32'h2, 1, 7,0, 1,1,1,32'h1,0,0, 0,14,32'hE0,2};
    vecs[20] = '{0,0,0, 0,0,0, 1, 7,0, 1,1,1,32'h2,0,0, 0,14,32'hE0,2};
    vecs[21] = '{0,0,0, 0,0,0, 0, 7,0, 1,1,1,32'h2,0,0, 1,7,32'h1,1};
    vecs[22] = '{0,0,0, 0,0,0, 0, 7,7, 1,1,1,32'h2,1,32'h2, 1,7,32'h2,0};
    vecs[23] = '{0,0,0, 0,0,0, 0, 7,0, 1,1,1,32'h2,0,0, 0,7,32'h2,0};
    // Test 5: x0 write accepted but discarded
    vecs[24] = '{0,0,0, 1,0,32'hFFFF, 0, 0,0, 1,1,0,0,0,0, 0,7,32'h2,0};
    vecs[25] = '{0,0,0, 0,0,0, 0, 0,0, 1,1,0,0,0,0, 0,7,32'h2,0};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    query_rd_1 = 5'd0;
    query_rd_2 = 5'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.mem_ready", 32'(mem_ready), 32'd0);
    chk("rst.alu_ready", 32'(alu_ready), 32'd0);
    chk_regs("rst", 1'b0, 5'd0, 32'd0, 3'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(vecs[i].mv, vecs[i].mrd, vecs[i].mdata, vecs[i].av, vecs[i].ard, vecs[i].adata,
            vecs[i].stl);
      query_rd_1 = vecs[i].q1;
      query_rd_2 = vecs[i].q2;
      #1;
      chk({tag, ".mem_ready"}, 32'(mem_ready), 32'(vecs[i].e_mr));
      chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(vecs[i].e_ar));
      chk({tag, ".busy_1"},    32'(busy_1),    32'(vecs[i].e_b1));
      chk({tag, ".fwd_1"},     fwd_data_1,     vecs[i].e_f1);
      chk({tag, ".busy_2"},    32'(busy_2),    32'(vecs[i].e_b2));
      chk({tag, ".fwd_2"},     fwd_data_2,     vecs[i].e_f2);
      @(posedge clock);
      #1;
      chk_regs(tag, vecs[i].e_we, vecs[i].e_sel, vecs[i].e_data, vecs[i].e_cnt);
    end

    // Test 6: reset mid-drain with three entries buffered
    query_rd_1 = 5'd2;
    query_rd_2 = 5'd4;
    for (int r = 1; r <= 3; r++) begin
      drive(0, 0, 0, 1, 5'(r), 32'(r * 17), 1);
      @(posedge clock);
      #1;
    end
    drive(0, 0, 0, 1, 5'd4, 32'h44, 0);
    @(posedge clock);
    #1;
    chk_regs("t6.pre", 1'b1, 5'd1, 32'd17, 3'd3);
    chk("t6.pre.busy_1", 32'(busy_1), 32'd1);
    chk("t6.pre.fwd_1",  fwd_data_1,  32'd34);
    chk("t6.pre.busy_2", 32'(busy_2), 32'd1);
    reset = 1'b1;
    drive(1, 5'd9, 32'h99, 1, 5'd8, 32'h88, 0);
    #1;
    chk("t6.rst.mem_ready", 32'(mem_ready), 32'd0);
    chk("t6.rst.alu_ready", 32'(alu_ready), 32'd0);
    @(posedge clock);
    #1;
    chk_regs("t6.post", 1'b0, 5'd0, 32'd0, 3'd0);
    chk("t6.post.busy_1", 32'(busy_1), 32'd0);
    chk("t6.post.busy_2", 32'(busy_2), 32'd0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    chk_regs("t6.idle", 1'b0, 5'd0, 32'd0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
